usb_pin_if_x7: RTL and testbench
================================

# usb_pin_if_x7

Parametrised USB full-speed pin interface for the Xilinx 7-series flow. It sits between `usb_uart_core_np` (or any core exposing `usb_p_tx/usb_n_tx/usb_tx_en/usb_p_rx/usb_n_rx`) and the top-level D+/D- pads. It adds the following:
- registered drive;
- a parametrised RX synchroniser;
- RX masking during transmit plus a configurable turnaround guard;
- line-state reporting;
- SE0 bus-reset detection.

## Interface

Parameters:
- `DRIVE` — default 16 — IOBUF drive strength.
- `SLEW` — default "FAST" — IOBUF slew rate.
- `SYNC_STAGES` — default 2 — RX synchroniser depth. Legal range 2–4.
- `TURNAROUND` — default 2 — extra cycles the RX stays masked after the pads are released. Legal range 0–15.
- `SE0_RESET_CYCLES` — default 120 — consecutive unmasked SE0 cycles that declare a bus reset (2.5 µs at 48 MHz). Must be ≥1.

Ports:
- `clk_48mhz` — in — 1 — sole clock.
- `reset_n` — in — 1 — reset, synchronous, active-low.
- `pin_usb_p` — inout — 1 — D+ pad.
- `pin_usb_n` — inout — 1 — D- pad.
- `usb_p_tx` — in — 1 — core D+ transmit level.
- `usb_n_tx` — in — 1 — core D- transmit level.
- `usb_tx_en` — in — 1 — core output enable.
- `usb_p_rx` — out — 1 — D+ receive level to the core; forced to 1 when masked.
- `usb_n_rx` — out — 1 — D- receive level to the core; forced to 0 when masked.
- `line_state` — out — 2 — synchronised `{D+, D-}`: 2'b10 = J, 2'b01 = K, 2'b00 = SE0, 2'b11 = SE1. Not masked.
- `rx_masked` — out — 1 — high while `usb_p_rx`/`usb_n_rx` are forced to J.
- `bus_reset` — out — 1 — level; high while a qualified SE0 persists.
- `bus_reset_pulse` — out — 1 — single-cycle strobe on the rising edge of `bus_reset`.

## Operation

TX path:
- `usb_p_tx`, `usb_n_tx` and `usb_tx_en` are registered once into `p_q`, `n_q` and `en_q`.
- The IOBUFs use `I = p_q` / `n_q` and `T = !en_q`.
- When `en_q = 0`, the pads are tri-stated.

RX path:
- Each IOBUF `O` passes through a `SYNC_STAGES`-deep flop chain.
- The last stage drives `line_state`.

Masking:
- `rx_masked = usb_tx_en | en_q | (guard != 0)`. This is combinational, so the core never sees its own transmission, starting in the same cycle it raises `usb_tx_en`.
- When masked: `usb_p_rx = 1`, `usb_n_rx = 0`.
- When unmasked: `usb_p_rx/usb_n_rx = line_state`.

Guard counter:
- Width is `$clog2(TURNAROUND+SYNC_STAGES+1)`.
- Load `TURNAROUND + SYNC_STAGES` on the cycle `en_q` goes 1→0.
- Decrement by 1 per cycle while nonzero.
- Clear to 0 whenever `usb_tx_en = 1` (a new transmit overrides the guard).

SE0 counter:
- Width is `$clog2(SE0_RESET_CYCLES+1)`.
- Clear when `line_state != 2'b00` or `rx_masked = 1`.
- Otherwise increment, saturating at `SE0_RESET_CYCLES`.
- `bus_reset = (se0_cnt == SE0_RESET_CYCLES)`, registered.
- `bus_reset_pulse` is high for exactly one cycle when `bus_reset` goes 0→1.

Reset (`reset_n = 0` sampled at an edge):
- `p_q = 0`, `n_q = 0`, `en_q = 0` (pads released).
- All synchroniser stages are set to J (D+ = 1, D- = 0), so `line_state = 2'b10`.
- `guard = 0`, `se0_cnt = 0`, `bus_reset = 0`, `bus_reset_pulse = 0`.
- After reset: `rx_masked = usb_tx_en`, `usb_p_rx = 1`, `usb_n_rx = 0`.
- Reset mid-transmit: pads release on the reset edge and no guard is loaded.

## Timing

- Core → pad: 1 cycle. `usb_tx_en` sampled high at edge n means the pad is driven after edge n.
- Pad → `line_state`: `SYNC_STAGES` cycles.
- Mask end: `en_q` falls at edge m. `rx_masked` stays high through cycle m + `TURNAROUND` + `SYNC_STAGES`. The RX is first unmasked in the following cycle.
- Bus reset timing:
  - `bus_reset` rises `SE0_RESET_CYCLES + 1` cycles after the first unmasked SE0 appears on `line_state`.
  - It falls 1 cycle after `line_state` leaves SE0.
  - It also falls 1 cycle after masking begins.
- Simultaneous events:
  - `usb_tx_en` rising while `guard != 0`: the guard clears and the mask stays continuous.
  - SE0 during masking: the counter is held at 0.
  - SE1: treated as non-SE0; the counter clears.

## Test plan

1. **Reset values.** Hold `reset_n = 0` for 3 cycles with the pads floating high-Z/pulled J.
   - Pads tri-stated.
   - `line_state = 2'b10`, `usb_p_rx = 1`, `usb_n_rx = 0`, `bus_reset = 0`, `rx_masked = 0`.
2. **Transmit and turnaround.** Defaults. Raise `usb_tx_en` at cycle 10 and drop it at cycle 20; drive K (0/1) at the pads from the bench after release.
   - Pads driven during cycles 11–20.
   - `rx_masked` high during cycles 10–24.
   - `usb_p_rx/usb_n_rx` show K from cycle 25.
3. **Bus reset.** Defaults. Drive SE0 on the pads for 200 cycles, then J.
   - `bus_reset` rises 123 cycles after the pad change (2 sync + 121).
   - `bus_reset_pulse` is high for exactly 1 cycle.
   - `bus_reset` falls 3 cycles after J returns.
4. **SE0 too short or masked.**
   - SE0 for 100 cycles: `bus_reset` stays 0.
   - SE0 for 200 cycles with `usb_tx_en` pulsed for 1 cycle at SE0 cycle 60: the counter restarts and `bus_reset` rises 121 cycles after the mask ends.
5. **Back-to-back transmit.** Drop `usb_tx_en` for 1 cycle, then re-raise it.
   - `rx_masked` never deasserts.
   - The guard is 0 after the re-raise.
   - Pads released for exactly 1 cycle.
6. **Reset mid-transmit and parameter sweep.**
   - Assert `reset_n = 0` while `en_q = 1`: pads release next edge; after reset `rx_masked = usb_tx_en` with no guard, and `rx_masked` falls in the first cycle `usb_tx_en = 0`.
   - Repeat scenario 2 with `TURNAROUND = 0` and `SYNC_STAGES = 3`: the mask ends 3 cycles after `en_q` falls.

Source files
------------

// File: rtl/usb_pin_if_x7.sv
// USB full-speed pad interface: registered D+/D- drive, RX synchroniser, RX masking
// with turnaround guard, line-state reporting and SE0 bus-reset detection.
module usb_pin_if_x7 #(
  parameter int DRIVE            = 16,
  parameter     SLEW             = "FAST",
  parameter int SYNC_STAGES      = 2,
  parameter int TURNAROUND       = 2,
  parameter int SE0_RESET_CYCLES = 120
) (
  input  logic       clk_48mhz,
  input  logic       reset_n,
  inout  wire        pin_usb_p,
  inout  wire        pin_usb_n,
  input  logic       usb_p_tx,
  input  logic       usb_n_tx,
  input  logic       usb_tx_en,
  output logic       usb_p_rx,
  output logic       usb_n_rx,
  output logic [1:0] line_state,
  output logic       rx_masked,
  output logic       bus_reset,
  output logic       bus_reset_pulse
);

  localparam int GUARD_LOAD = TURNAROUND + SYNC_STAGES;
  localparam int GW         = $clog2(GUARD_LOAD + 1);
  localparam int SW         = $clog2(SE0_RESET_CYCLES + 1);
  localparam logic [GW-1:0] GUARD_INIT = GW'(GUARD_LOAD);
  localparam logic [SW-1:0] SE0_MAX    = SW'(SE0_RESET_CYCLES);

  // DRIVE and SLEW are applied to the pads by the 7-series IO constraints; here they are only range-checked.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TURNAROUND < 0 || TURNAROUND > 15 ||
      SE0_RESET_CYCLES < 1 || DRIVE < 1 ||
      (SLEW != "FAST" && SLEW != "SLOW")) begin : g_param_check
    $error("usb_pin_if_x7: illegal parameter value");
  end

  logic                   r_p_q;
  logic                   r_n_q;
  logic                   r_en_q;
  logic [SYNC_STAGES-1:0] r_sync_p;
  logic [SYNC_STAGES-1:0] r_sync_n;
  logic [GW-1:0]          r_guard;
  logic [SW-1:0]          r_se0_cnt;
  logic                   r_bus_reset;
  logic                   r_bus_reset_pulse;

  logic w_pad_p;
  logic w_pad_n;
  logic w_guard_busy;
  logic w_se0_qual;
  logic w_bus_reset_d;

  // Pads are driven only while the registered enable is high; otherwise released.
  assign pin_usb_p = r_en_q ? r_p_q : 1'bz;
  assign pin_usb_n = r_en_q ? r_n_q : 1'bz;
  assign w_pad_p   = pin_usb_p;
  assign w_pad_n   = pin_usb_n;

  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      r_p_q  <= 1'b0;
      r_n_q  <= 1'b0;
      r_en_q <= 1'b0;
    end else begin
      r_p_q  <= usb_p_tx;
      r_n_q  <= usb_n_tx;
      r_en_q <= usb_tx_en;
    end
  end

  // Synchroniser resets to J so the core sees an idle bus straight out of reset.
  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      r_sync_p <= '1;
      r_sync_n <= '0;
    end else begin
      r_sync_p <= {r_sync_p[SYNC_STAGES-2:0], w_pad_p};
      r_sync_n <= {r_sync_n[SYNC_STAGES-2:0], w_pad_n};
    end
  end

  assign line_state = {r_sync_p[SYNC_STAGES-1], r_sync_n[SYNC_STAGES-1]};

  // Guard covers our own echo still in the synchroniser plus the extra turnaround.
  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      r_guard <= '0;
    end else if (usb_tx_en) begin
      r_guard <= '0;
    end else if (r_en_q) begin
      r_guard <= GUARD_INIT;
    end else if (w_guard_busy) begin
      r_guard <= r_guard - 1'b1;
    end
  end

  assign w_guard_busy = (r_guard != '0);
  assign rx_masked    = usb_tx_en | r_en_q | w_guard_busy;
  assign usb_p_rx     = rx_masked | line_state[1];
  assign usb_n_rx     = ~rx_masked & line_state[0];

  assign w_se0_qual    = (line_state == 2'b00) && !rx_masked;
  assign w_bus_reset_d = w_se0_qual && (r_se0_cnt == SE0_MAX);

  always_ff @(posedge clk_48mhz) begin
    if (!reset_n) begin
      r_se0_cnt         <= '0;
      r_bus_reset       <= 1'b0;
      r_bus_reset_pulse <= 1'b0;
    end else begin
      if (!w_se0_qual) begin
        r_se0_cnt <= '0;
      end else if (r_se0_cnt != SE0_MAX) begin
        r_se0_cnt <= r_se0_cnt + 1'b1;
      end
      r_bus_reset       <= w_bus_reset_d;
      r_bus_reset_pulse <= w_bus_reset_d && !r_bus_reset;
    end
  end

  assign bus_reset       = r_bus_reset;
  assign bus_reset_pulse = r_bus_reset_pulse;

endmodule

// File: tb/tb_usb_pin_if_x7.sv
// Bench for usb_pin_if_x7: two parameter sets driven in lockstep, checked every cycle
// against a window/run-length model of the pad interface plus directed timing checks.
module tb_usb_pin_if_x7;

  localparam int S0 = 2, T0 = 2, R0 = 120;
  localparam int S1 = 3, T1 = 0, R1 = 20;
  localparam logic [1:0] LJ = 2'b10, LK = 2'b01, LSE0 = 2'b00;

  logic       clk       = 1'b0;
  logic       reset_n   = 1'b0;
  logic       usb_p_tx  = 1'b0;
  logic       usb_n_tx  = 1'b0;
  logic       usb_tx_en = 1'b0;
  logic [1:0] tb_pad    = 2'b10;

  wire        pin_p0, pin_n0, pin_p1, pin_n1;
  logic       p_rx0, n_rx0, p_rx1, n_rx1;
  logic       msk0, msk1, br0, br1, brp0, brp1;
  logic [1:0] ls0, ls1;

  // reference model state, one copy per instance
  logic       m_en_q    [2];
  logic       m_p_q     [2];
  logic       m_n_q     [2];
  logic [1:0] m_ls_hist [2][4];
  logic       m_en_hist [2][20];
  int         m_run     [2];
  logic       m_br      [2];
  logic       m_brp     [2];

  // values observed in the latest compared cycle
  logic       obs_msk0, obs_msk1, obs_br0, obs_br1, obs_brp0;
  logic [1:0] obs_rx0, obs_rx1, obs_pad0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  // bench holds the bus whenever the DUT is not driving it
  assign pin_p0 = m_en_q[0] ? 1'bz : tb_pad[1];
  assign pin_n0 = m_en_q[0] ? 1'bz : tb_pad[0];
  assign pin_p1 = m_en_q[1] ? 1'bz : tb_pad[1];
  assign pin_n1 = m_en_q[1] ? 1'bz : tb_pad[0];

  usb_pin_if_x7 #(.SYNC_STAGES(S0), .TURNAROUND(T0), .SE0_RESET_CYCLES(R0)) u_dut0 (
    .clk_48mhz(clk), .reset_n(reset_n), .pin_usb_p(pin_p0), .pin_usb_n(pin_n0),
    .usb_p_tx(usb_p_tx), .usb_n_tx(usb_n_tx), .usb_tx_en(usb_tx_en),
    .usb_p_rx(p_rx0), .usb_n_rx(n_rx0), .line_state(ls0), .rx_masked(msk0),
    .bus_reset(br0), .bus_reset_pulse(brp0));

  usb_pin_if_x7 #(.SYNC_STAGES(S1), .TURNAROUND(T1), .SE0_RESET_CYCLES(R1)) u_dut1 (
    .clk_48mhz(clk), .reset_n(reset_n), .pin_usb_p(pin_p1), .pin_usb_n(pin_n1),
    .usb_p_tx(usb_p_tx), .usb_n_tx(usb_n_tx), .usb_tx_en(usb_tx_en),
    .usb_p_rx(p_rx1), .usb_n_rx(n_rx1), .line_state(ls1), .rx_masked(msk1),
    .bus_reset(br1), .bus_reset_pulse(brp1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 50)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int f_s(input int i); return (i == 0) ? S0 : S1; endfunction
  function automatic int f_t(input int i); return (i == 0) ? T0 : T1; endfunction
  function automatic int f_r(input int i); return (i == 0) ? R0 : R1; endfunction

  // line state is the pad value delayed by the synchroniser depth
  function automatic logic [1:0] f_ls(input int i);
    return m_ls_hist[i][f_s(i)-1];
  endfunction

  // masked while transmitting or within TURNAROUND+SYNC_STAGES cycles of the last driven cycle
  function automatic logic f_masked(input int i);
    logic m;
    m = usb_tx_en | m_en_q[i];
    for (int j = 0; j < f_t(i) + f_s(i); j++) m = m | m_en_hist[i][j];
    return m;
  endfunction

  function automatic logic [1:0] f_pad(input int i);
    return m_en_q[i] ? {m_p_q[i], m_n_q[i]} : tb_pad;
  endfunction

  function automatic logic [1:0] f_rx(input int i);
    return f_masked(i) ? LJ : f_ls(i);
  endfunction

  task automatic model_reset(input int i);
    m_en_q[i] = 1'b0;
    m_p_q[i]  = 1'b0;
    m_n_q[i]  = 1'b0;
    for (int j = 0; j < 4; j++) m_ls_hist[i][j] = LJ;
    for (int j = 0; j < 20; j++) m_en_hist[i][j] = 1'b0;
    m_run[i] = 0;
    m_br[i]  = 1'b0;
    m_brp[i] = 1'b0;
  endtask

  // advance one clock edge using the inputs that were present before the edge
  task automatic model_step(input int i);
    logic [1:0] pad;
    logic       qual;
    logic       nbr;
    if (!reset_n) begin
      model_reset(i);
      return;
    end
    pad  = f_pad(i);
    qual = (f_ls(i) == LSE0) && !f_masked(i);
    m_run[i] = qual ? m_run[i] + 1 : 0;
    nbr      = (m_run[i] >= f_r(i) + 1);
    m_brp[i] = nbr && !m_br[i];
    m_br[i]  = nbr;
    for (int j = 19; j > 0; j--) m_en_hist[i][j] = m_en_hist[i][j-1];
    m_en_hist[i][0] = m_en_q[i];
    for (int j = 3; j > 0; j--) m_ls_hist[i][j] = m_ls_hist[i][j-1];
    m_ls_hist[i][0] = pad;
    m_en_q[i] = usb_tx_en;
    m_p_q[i]  = usb_p_tx;
    m_n_q[i]  = usb_n_tx;
  endtask

  task automatic run_cycle();
    #1;
    obs_msk0 = msk0; obs_msk1 = msk1; obs_br0 = br0; obs_br1 = br1; obs_brp0 = brp0;
    obs_rx0  = {p_rx0, n_rx0}; obs_rx1 = {p_rx1, n_rx1}; obs_pad0 = {pin_p0, pin_n0};
    check("line_state0", 32'(ls0), 32'(f_ls(0)));
    check("rx0", 32'({p_rx0, n_rx0}), 32'(f_rx(0)));
    check("rx_masked0", 32'(msk0), 32'(f_masked(0)));
    check("bus_reset0", 32'(br0), 32'(m_br[0]));
    check("bus_reset_pulse0", 32'(brp0), 32'(m_brp[0]));
    check("pad0", 32'({pin_p0, pin_n0}), 32'(f_pad(0)));
    check("line_state1", 32'(ls1), 32'(f_ls(1)));
    check("rx1", 32'({p_rx1, n_rx1}), 32'(f_rx(1)));
    check("rx_masked1", 32'(msk1), 32'(f_masked(1)));
    check("bus_reset1", 32'(br1), 32'(m_br[1]));
    check("bus_reset_pulse1", 32'(brp1), 32'(m_brp[1]));
    check("pad1", 32'({pin_p1, pin_n1}), 32'(f_pad(1)));
    @(posedge clk);
    #1;
    model_step(0);
    model_step(1);
    cyc++;
  endtask

  task automatic drv(input logic en, input logic p, input logic n, input logic [1:0] pad);
    usb_tx_en = en;
    usb_p_tx  = p;
    usb_n_tx  = n;
    tb_pad    = pad;
    run_cycle();
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) drv(1'b0, 1'b0, 1'b0, LJ);
  endtask

  int first0, last0, last1, cnt0, rx_k0, rx_k1, rise0, rise1, npulse, fall0, fall1, nrel;
  int len, en_len, rst_len;
  logic [1:0] pv;

  initial begin
    model_reset(0);
    model_reset(1);
    @(posedge clk);
    #1;
    model_step(0);
    model_step(1);

    // reset values
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) drv(1'b0, 1'b0, 1'b0, LJ);
    check("reset_line_state", 32'(ls0), 32'(LJ));
    check("reset_rx_masked", 32'(msk0), 32'(0));
    reset_n = 1'b1;

    // transmit J, bench drives K once released
    first0 = -1; last0 = -1; last1 = -1; cnt0 = 0; rx_k0 = -1; rx_k1 = -1;
    for (int k = 0; k < 40; k++) begin
      drv((k >= 10) && (k < 20), 1'b1, 1'b0, LK);
      if (obs_msk0) begin cnt0++; last0 = k; if (first0 < 0) first0 = k; end
      if (obs_msk1) last1 = k;
      if (k >= 21 && rx_k0 < 0 && obs_rx0 == LK) rx_k0 = k;
      if (k >= 21 && rx_k1 < 0 && obs_rx1 == LK) rx_k1 = k;
    end
    check("tx_mask_first", 32'(first0), 32'(10));
    check("tx_mask_last", 32'(last0), 32'(24));
    check("tx_mask_count", 32'(cnt0), 32'(15));
    check("tx_rx_k_cycle", 32'(rx_k0), 32'(25));
    check("tx_mask_last_t0s3", 32'(last1), 32'(23));
    check("tx_rx_k_cycle_t0s3", 32'(rx_k1), 32'(24));

    // long SE0 bus reset
    idle(10);
    rise0 = -1; rise1 = -1; npulse = 0;
    for (int k = 0; k < 200; k++) begin
      drv(1'b0, 1'b0, 1'b0, LSE0);
      if (obs_br0 && rise0 < 0) rise0 = k;
      if (obs_br1 && rise1 < 0) rise1 = k;
      if (obs_brp0) npulse++;
    end
    check("se0_rise", 32'(rise0), 32'(123));
    check("se0_rise_s3", 32'(rise1), 32'(24));
    check("se0_pulse_count", 32'(npulse), 32'(1));
    fall0 = -1; fall1 = -1;
    for (int k = 0; k < 10; k++) begin
      drv(1'b0, 1'b0, 1'b0, LJ);
      if (!obs_br0 && fall0 < 0) fall0 = k;
      if (!obs_br1 && fall1 < 0) fall1 = k;
    end
    check("se0_fall", 32'(fall0), 32'(3));
    check("se0_fall_s3", 32'(fall1), 32'(4));

    // SE0 too short
    idle(10);
    cnt0 = 0;
    for (int k = 0; k < 100; k++) begin
      drv(1'b0, 1'b0, 1'b0, LSE0);
      if (obs_br0) cnt0++;
    end
    check("se0_short_no_reset", 32'(cnt0), 32'(0));

    // SE0 interrupted by a one-cycle transmit
    idle(10);
    rise0 = -1;
    for (int k = 0; k < 200; k++) begin
      drv(k == 60, 1'b0, 1'b0, LSE0);
      if (obs_br0 && rise0 < 0) rise0 = k;
    end
    check("se0_masked_rise", 32'(rise0), 32'(187));

    // back-to-back transmit with a one-cycle gap
    idle(10);
    cnt0 = 0; nrel = 0;
    for (int k = 0; k < 25; k++) begin
      drv((k < 10) || ((k >= 11) && (k < 21)), 1'b1, 1'b1, LSE0);
      if (k <= 20 && !obs_msk0) cnt0++;
      if (k >= 1 && k <= 21 && obs_pad0 == LSE0) nrel++;
    end
    check("b2b_mask_gaps", 32'(cnt0), 32'(0));
    check("b2b_pad_released", 32'(nrel), 32'(1));

    // reset in the middle of a transmit
    idle(10);
    for (int k = 0; k < 12; k++) begin
      reset_n = !((k >= 3) && (k <= 5));
      drv(k <= 5, 1'b1, 1'b0, LJ);
      if (k == 6) begin
        check("rst_mid_tx_mask0", 32'(obs_msk0), 32'(0));
        check("rst_mid_tx_mask1", 32'(obs_msk1), 32'(0));
      end
    end
    reset_n = 1'b1;

    // randomized segments checked against the model
    for (int seg = 0; seg < 70; seg++) begin
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(100, 160) : $urandom_range(1, 40);
      pv  = ($urandom_range(0, 1) == 0) ? LSE0 : 2'($urandom_range(0, 3));
      en_len  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
      rst_len = ($urandom_range(0, 19) == 0) ? 2 : 0;
      for (int k = 0; k < len; k++) begin
        reset_n = (k >= rst_len);
        drv(k < en_len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pv);
      end
    end
    reset_n = 1'b1;
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
